// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: sizing defaults,
// register index type and the issue-type codes that classify long ops.
package reg_scoreboard_pkg;

   localparam int NREG_DEF  = 32;
   localparam int CNT_W_DEF = 2;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [2:0] {
      ITYPE_ALU = 3'd0,
      ITYPE_BR  = 3'd1,
      ITYPE_MUL = 3'd2,
      ITYPE_MEM = 3'd3,
      ITYPE_DIV = 3'd4,
      ITYPE_CSR = 3'd5
   } itype_e;

   // Upstream decode drives eu*_long from this.
   function automatic logic itype_is_long(input itype_e t);
      return (t == ITYPE_MUL) || (t == ITYPE_MEM) || (t == ITYPE_DIV);
   endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter with clamp-at-zero and max flags.
// Underflow output exists only when SCOREBOARD_STATS_EN is defined.
module sb_counter
   import reg_scoreboard_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc0,
   input  logic             inc1,
   input  logic             dec0,
   input  logic             dec1,
   output logic [CNT_W-1:0] cnt,
   output logic             at_max,
   output logic             near_max
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic             underflow
`endif
);

   localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W:0]   up;
   logic [CNT_W:0]   dn;
   logic [CNT_W:0]   sum;
   logic [CNT_W:0]   diff;
   logic             clamp;
   logic [CNT_W-1:0] nxt;

   always_comb begin
      up    = {{CNT_W{1'b0}}, inc0} + {{CNT_W{1'b0}}, inc1};
      dn    = {{CNT_W{1'b0}}, dec0} + {{CNT_W{1'b0}}, dec1};
      sum   = {1'b0, cnt} + up;
      clamp = (sum < dn);
      diff  = sum - dn;
      nxt   = cnt;
      if (clr)
         nxt = '0;
      else if (clamp)
         nxt = '0;
      else if (diff > MAX)
         nxt = MAX[CNT_W-1:0];
      else
         nxt = diff[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= nxt;
   end

   assign at_max   = ({1'b0, cnt} == MAX);
   assign near_max = ({1'b0, cnt} >= (MAX - 1'b1));

`ifdef SCOREBOARD_STATS_EN
   assign underflow = !clr && clamp;
`endif

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the dual-issue rf stage; raises sb_stall on
// RAW hazards and counter-full. SCOREBOARD_STATS_EN adds stall/underflow stats.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREG  = NREG_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            eu0_en,
   input  logic [4:0]      eu0_rj,
   input  logic [4:0]      eu0_rk,
   input  logic [4:0]      eu0_rd,
   input  logic            eu0_long,
   input  logic            eu1_en,
   input  logic [4:0]      eu1_rj,
   input  logic [4:0]      eu1_rk,
   input  logic [4:0]      eu1_rd,
   input  logic            eu1_long,
   input  logic            ext_stall,
   input  logic            wb0_en,
   input  logic [4:0]      wb0_rd,
   input  logic            wb1_en,
   input  logic [4:0]      wb1_rd,
   output logic            sb_stall,
   output logic [NREG-1:0] busy_vec
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic            sb_underflow
`endif
);

   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0]            at_max;
   logic [NREG-1:0]            near_max;

   logic wr0;
   logic wr1;
   logic pair;
   logic raw0;
   logic raw1;
   logic full0;
   logic full1;
   logic fire;
   logic wbv0;
   logic wbv1;

   // A slot writes only when it is a valid long op with a real rd.
   assign wr0  = eu0_en && eu0_long && (eu0_rd != '0);
   assign wr1  = eu1_en && eu1_long && (eu1_rd != '0);
   assign pair = wr0 && wr1 && (eu0_rd == eu1_rd);
   assign wbv0 = wb0_en && (wb0_rd != '0);
   assign wbv1 = wb1_en && (wb1_rd != '0);

   assign raw0 = eu0_en && (busy_vec[eu0_rj] || busy_vec[eu0_rk]);
   assign raw1 = eu1_en && (busy_vec[eu1_rj] || busy_vec[eu1_rk]);

   // Both slots hitting one rd add two, so they need one more free slot.
   assign full0 = wr0 && (pair ? near_max[eu0_rd] : at_max[eu0_rd]);
   assign full1 = wr1 && (pair ? near_max[eu1_rd] : at_max[eu1_rd]);

   assign sb_stall = raw0 || raw1 || full0 || full1;

   assign fire = (eu0_en || eu1_en) && !sb_stall && !ext_stall && !flush;

   assign cnt[0]      = '0;
   assign at_max[0]   = 1'b0;
   assign near_max[0] = 1'b0;

`ifdef SCOREBOARD_STATS_EN
   logic [NREG-1:1] uf;
`endif

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      sb_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .clr      (flush),
         .inc0     (fire && wr0 && (eu0_rd == reg_idx_t'(i))),
         .inc1     (fire && wr1 && (eu1_rd == reg_idx_t'(i))),
         .dec0     (wbv0 && (wb0_rd == reg_idx_t'(i))),
         .dec1     (wbv1 && (wb1_rd == reg_idx_t'(i))),
         .cnt      (cnt[i]),
         .at_max   (at_max[i]),
         .near_max (near_max[i])
`ifdef SCOREBOARD_STATS_EN
         ,
         .underflow(uf[i])
`endif
      );
   end

   always_comb begin
      busy_vec = '0;
      for (int i = 1; i < NREG; i++)
         busy_vec[i] = (cnt[i] != '0);
   end

`ifdef SCOREBOARD_STATS_EN
   logic stall_ev;

   assign stall_ev = sb_stall && (eu0_en || eu1_en) && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cycles <= '0;
      else if (stall_ev && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sb_underflow <= 1'b0;
      else if (|uf)
         sb_underflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard with an expected-result queue.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        eu0_en, eu0_long, eu1_en, eu1_long;
   logic [4:0]  eu0_rj, eu0_rk, eu0_rd;
   logic [4:0]  eu1_rj, eu1_rk, eu1_rd;
   logic        ext_stall;
   logic        wb0_en, wb1_en;
   logic [4:0]  wb0_rd, wb1_rd;
   logic        sb_stall;
   logic [31:0] busy_vec;
`ifdef SCOREBOARD_STATS_EN
   logic [31:0] stall_cycles;
   logic        sb_underflow;
`endif

   reg_scoreboard dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .eu0_en   (eu0_en),
      .eu0_rj   (eu0_rj),
      .eu0_rk   (eu0_rk),
      .eu0_rd   (eu0_rd),
      .eu0_long (eu0_long),
      .eu1_en   (eu1_en),
      .eu1_rj   (eu1_rj),
      .eu1_rk   (eu1_rk),
      .eu1_rd   (eu1_rd),
      .eu1_long (eu1_long),
      .ext_stall(ext_stall),
      .wb0_en   (wb0_en),
      .wb0_rd   (wb0_rd),
      .wb1_en   (wb1_en),
      .wb1_rd   (wb1_rd),
      .sb_stall (sb_stall),
      .busy_vec (busy_vec)
`ifdef SCOREBOARD_STATS_EN
      ,
      .stall_cycles(stall_cycles),
      .sb_underflow(sb_underflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        e0, l0;
      logic [4:0]  j0, k0, d0;
      logic        e1, l1;
      logic [4:0]  j1, k1, d1;
      logic        xs;
      logic        w0;
      logic [4:0]  r0;
      logic        w1;
      logic [4:0]  r1;
      logic        fl;
      logic        st;
      logic [31:0] busy;
   } vec_t;

   typedef struct {
      logic        st;
      logic [31:0] busy;
      string       name;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] b(input int n);
      return 32'd1 << n;
   endfunction

   function automatic vec_t v(
      input int e0, l0, j0, k0, d0,
      input int e1, l1, j1, k1, d1,
      input int xs, w0, r0, w1, r1, fl,
      input int st, input logic [31:0] busy);
      vec_t x;
      x.e0 = 1'(e0); x.l0 = 1'(l0);
      x.j0 = 5'(j0); x.k0 = 5'(k0); x.d0 = 5'(d0);
      x.e1 = 1'(e1); x.l1 = 1'(l1);
      x.j1 = 5'(j1); x.k1 = 5'(k1); x.d1 = 5'(d1);
      x.xs = 1'(xs);
      x.w0 = 1'(w0); x.r0 = 5'(r0);
      x.w1 = 1'(w1); x.r1 = 5'(r1);
      x.fl = 1'(fl);
      x.st = 1'(st);
      x.busy = busy;
      return x;
   endfunction

   task automatic drive(input vec_t x);
      eu0_en = x.e0; eu0_long = x.l0;
      eu0_rj = x.j0; eu0_rk = x.k0; eu0_rd = x.d0;
      eu1_en = x.e1; eu1_long = x.l1;
      eu1_rj = x.j1; eu1_rk = x.k1; eu1_rd = x.d1;
      ext_stall = x.xs;
      wb0_en = x.w0; wb0_rd = x.r0;
      wb1_en = x.w1; wb1_rd = x.r1;
      flush = x.fl;
   endtask

   task automatic push(input logic st, input logic [31:0] busy, input string name);
      exp_t e;
      e.st = st;
      e.busy = busy;
      e.name = name;
      sbq.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (sb_stall !== e.st) begin
         errors++;
         $display("FAIL %s sb_stall got %0b want %0b", e.name, sb_stall, e.st);
      end
      checks++;
      if (busy_vec !== e.busy) begin
         errors++;
         $display("FAIL %s busy_vec got %h want %h", e.name, busy_vec, e.busy);
      end
   endtask

   initial begin
      vec_t idle;
      int   exp_stalls;
      idle = v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0);

      // basic RAW on r5
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,5, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(0,0,0,0,0, 1,0,5,0,0, 0,0,0,0,0, 0, 1,b(5)));
      tbl.push_back(v(0,0,0,0,0, 1,0,5,0,0, 0,1,5,0,0, 0, 1,b(5)));
      tbl.push_back(v(0,0,0,0,0, 1,0,5,0,0, 0,0,0,0,0, 0, 0,32'd0));
      // WAW depth on r7
      tbl.push_back(v(1,1,0,0,7, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,7, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(7)));
      tbl.push_back(v(1,1,0,0,7, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(7)));
      tbl.push_back(v(1,1,0,0,7, 0,0,0,0,0, 0,0,0,0,0, 0, 1,b(7)));
      tbl.push_back(v(1,1,0,0,7, 0,0,0,0,0, 0,1,7,0,0, 0, 1,b(7)));
      tbl.push_back(v(1,1,0,0,7, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(7)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,1,7,1,7, 0, 0,b(7)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,1,7,0,0, 0, 0,b(7)));
      // same-cycle inc/dec and dual writeback on r9
      tbl.push_back(v(1,1,0,0,9, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,9, 0,0,0,0,0, 0,1,9,0,0, 0, 0,b(9)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(9)));
      tbl.push_back(v(1,1,0,0,9, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(9)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,1,9,1,9, 0, 0,b(9)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      // pair targeting same rd uses max-1 threshold
      tbl.push_back(v(1,1,0,0,10, 1,1,0,0,10, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,10, 1,1,0,0,10, 0,0,0,0,0, 0, 1,b(10)));
      tbl.push_back(v(1,1,0,0,10, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(10)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,1,10,1,10, 0, 0,b(10)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,1,10,0,0, 0, 0,b(10)));
      // r0 and ext_stall gating
      tbl.push_back(v(1,1,0,0,0, 1,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,6, 0,0,0,0,0, 1,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      // flush clears everything and ignores same-cycle issue
      tbl.push_back(v(1,1,0,0,3, 1,1,0,0,3, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,4, 0,0,0,0,0, 0,0,0,0,0, 0, 0,b(3)));
      tbl.push_back(v(1,1,0,0,8, 0,0,0,0,0, 0,1,3,0,0, 1, 0,b(3)|b(4)));
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      // clamped decrement, then rk hazards
      tbl.push_back(v(0,0,0,0,0, 0,0,0,0,0, 0,1,12,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,1,0,0,11, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      tbl.push_back(v(1,0,0,11,0, 0,0,0,0,0, 0,0,0,0,0, 0, 1,b(11)));
      tbl.push_back(v(0,0,0,0,0, 1,0,0,11,0, 0,0,0,1,11, 0, 1,b(11)));
      tbl.push_back(v(0,0,0,0,0, 1,0,0,11,0, 0,0,0,0,0, 0, 0,32'd0));

      rst = 1'b1;
      drive(idle);
      repeat (3) @(posedge clk);
      #1;
      push(1'b0, 32'd0, "reset");
      #2 pop_check();
      rst = 1'b0;

      exp_stalls = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         push(tbl[i].st, tbl[i].busy, $sformatf("row%0d", i));
         if (tbl[i].st && (tbl[i].e0 || tbl[i].e1) && !tbl[i].fl)
            exp_stalls++;
         #3 pop_check();
         @(posedge clk);
         #1;
      end

`ifdef SCOREBOARD_STATS_EN
      checks++;
      if (stall_cycles !== 32'(exp_stalls)) begin
         errors++;
         $display("FAIL stall_cycles got %0d want %0d", stall_cycles, exp_stalls);
      end
      checks++;
      if (sb_underflow !== 1'b1) begin
         errors++;
         $display("FAIL sb_underflow got %0b want 1", sb_underflow);
      end
`endif

      // async reset between edges drops pending state at once
      drive(v(1,1,0,0,13, 0,0,0,0,0, 0,0,0,0,0, 0, 0,32'd0));
      @(posedge clk);
      #1;
      drive(v(0,0,0,0,0, 1,0,13,0,0, 0,0,0,0,0, 0, 0,32'd0));
      push(1'b1, b(13), "pre_rst");
      #1 pop_check();
      #2;
      rst = 1'b1;
      push(1'b0, 32'd0, "async_rst");
      #1 pop_check();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      push(1'b0, 32'd0, "post_rst");
      pop_check();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
